// File: rtl/manch_rx_ctrl.sv
// Receive-side frame controller for the Manchester link: preamble lock, sync word,
// length, payload and XOR checksum, with a bit-activity watchdog.
module manch_rx_ctrl #(
  parameter int          CLK_FREQ      = 18_750_000,
  parameter int          BIT_RATE      = 115200,
  parameter int          PREAMBLE_BITS = 8,
  parameter logic [7:0]  SYNC_WORD     = 8'hD5,
  parameter int          SYNC_WINDOW   = 32,
  parameter int          MAX_LEN       = 64,
  parameter int          TIMEOUT_BITS  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_bit_dat,
  input  logic       i_bit_vld,
  output logic       o_dec_en,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_vld,
  output logic [7:0] o_rx_len,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  localparam int TO_CYC = TIMEOUT_BITS * (CLK_FREQ / BIT_RATE);
  localparam int WD_W   = $clog2(TO_CYC + 1);
  localparam int CW     = ($clog2(SYNC_WINDOW + 1) > 3) ? $clog2(SYNC_WINDOW + 1) : 3;
  localparam int AW     = $clog2(PREAMBLE_BITS + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HUNT = 3'd1;
  localparam logic [2:0] S_SYNC = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  logic [2:0]      r_state;
  logic [6:0]      r_shreg;
  logic [CW-1:0]   r_bit_cnt;
  logic [AW-1:0]   r_alt_cnt;
  logic [7:0]      r_byte_cnt;
  logic [7:0]      r_chk;
  logic [WD_W-1:0] r_wd_cnt;
  logic [7:0]      r_rx_byte;
  logic            r_rx_byte_vld;
  logic [7:0]      r_rx_len;
  logic            r_frame_start;
  logic            r_frame_done;
  logic            r_frame_err;
  logic [1:0]      r_err_code;

  // Byte as it will look once the incoming bit is shifted in; fields are judged on this.
  logic [7:0]    w_byte;
  logic [AW-1:0] w_alt_next;
  logic [CW-1:0] w_bit_inc;
  logic          w_field_done;
  logic          w_len_ok;
  logic          w_wd_exp;
  logic [7:0]    w_byte_cnt_inc;

  assign w_byte         = {r_shreg, i_bit_dat};
  assign w_alt_next     = (r_alt_cnt != '0 && i_bit_dat == r_shreg[0]) ? AW'(1) : r_alt_cnt + AW'(1);
  assign w_bit_inc      = r_bit_cnt + CW'(1);
  assign w_field_done   = (r_bit_cnt == CW'(7));
  assign w_len_ok       = (w_byte != 8'd0) && (w_byte <= 8'(MAX_LEN));
  assign w_wd_exp       = (r_wd_cnt == WD_W'(TO_CYC - 1));
  assign w_byte_cnt_inc = r_byte_cnt + 8'd1;

  assign o_dec_en      = (r_state != S_IDLE);
  assign o_busy        = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign o_rx_byte     = r_rx_byte;
  assign o_rx_byte_vld = r_rx_byte_vld;
  assign o_rx_len      = r_rx_len;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;
  assign o_frame_err   = r_frame_err;
  assign o_err_code    = r_err_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_alt_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_chk         <= '0;
      r_wd_cnt      <= '0;
      r_rx_byte     <= '0;
      r_rx_byte_vld <= 1'b0;
      r_rx_len      <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= '0;
    end else begin
      r_rx_byte_vld <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      if (!i_en || r_state == S_IDLE) begin
        // Dropping en abandons any partial field; no error is reported.
        r_state   <= i_en ? S_HUNT : S_IDLE;
        r_bit_cnt <= '0;
        r_alt_cnt <= '0;
        r_wd_cnt  <= '0;
      end else if (i_bit_vld) begin
        r_shreg  <= w_byte[6:0];
        r_wd_cnt <= '0;
        case (r_state)
          S_HUNT: begin
            if (w_alt_next == AW'(PREAMBLE_BITS)) begin
              r_state   <= S_SYNC;
              r_alt_cnt <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_alt_cnt <= w_alt_next;
            end
          end
          S_SYNC: begin
            if (w_bit_inc >= CW'(8) && w_byte == SYNC_WORD) begin
              r_frame_start <= 1'b1;
              r_state       <= S_LEN;
              r_bit_cnt     <= '0;
            end else if (w_bit_inc == CW'(SYNC_WINDOW)) begin
              r_state   <= S_HUNT;
              r_bit_cnt <= '0;
              r_alt_cnt <= '0;
            end else begin
              r_bit_cnt <= w_bit_inc;
            end
          end
          S_LEN: begin
            if (w_field_done) begin
              r_bit_cnt <= '0;
              if (w_len_ok) begin
                r_rx_len   <= w_byte;
                r_chk      <= w_byte;
                r_byte_cnt <= '0;
                r_state    <= S_DATA;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= S_HUNT;
                r_alt_cnt   <= '0;
              end
            end else begin
              r_bit_cnt <= w_bit_inc;
            end
          end
          S_DATA: begin
            if (w_field_done) begin
              r_bit_cnt     <= '0;
              r_rx_byte     <= w_byte;
              r_rx_byte_vld <= 1'b1;
              r_chk         <= r_chk ^ w_byte;
              r_byte_cnt    <= w_byte_cnt_inc;
              if (w_byte_cnt_inc == r_rx_len) r_state <= S_CHK;
            end else begin
              r_bit_cnt <= w_bit_inc;
            end
          end
          S_CHK: begin
            if (w_field_done) begin
              r_bit_cnt <= '0;
              r_alt_cnt <= '0;
              r_state   <= S_HUNT;
              if (w_byte == r_chk) begin
                r_frame_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_CHK;
              end
            end else begin
              r_bit_cnt <= w_bit_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state == S_HUNT) begin
        r_wd_cnt <= '0;
      end else if (w_wd_exp) begin
        // Stalled line: a lost sync is dropped quietly, a stalled frame is reported.
        r_wd_cnt  <= '0;
        r_state   <= S_HUNT;
        r_bit_cnt <= '0;
        r_alt_cnt <= '0;
        if (r_state != S_SYNC) begin
          r_frame_err <= 1'b1;
          r_err_code  <= ERR_TO;
        end
      end else begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_manch_rx_ctrl.sv
// Directed and randomized frame reception test for manch_rx_ctrl; expected outcomes are
// derived from the frame contents sent (length range and XOR checksum).
module tb_manch_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       bit_dat = 1'b0;
  logic       bit_vld = 1'b0;
  logic       dec_en;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic [7:0] rx_len;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  manch_rx_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bit_dat(bit_dat), .i_bit_vld(bit_vld),
    .o_dec_en(dec_en), .o_rx_byte(rx_byte), .o_rx_byte_vld(rx_byte_vld), .o_rx_len(rx_len),
    .o_frame_start(frame_start), .o_frame_done(frame_done), .o_frame_err(frame_err),
    .o_err_code(err_code), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int s_start, s_done, s_err;
  logic [7:0] got_q[$];
  logic [7:0] pay[0:255];
  logic [3:0] last_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) n_start++;
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (rx_byte_vld) got_q.push_back(rx_byte);
      if (frame_start || frame_done || frame_err || rx_byte_vld)
        check("pulse_excl",
              ((int'(frame_start) + int'(frame_done) + int'(frame_err)) > 1) ||
              (rx_byte_vld && (frame_done || frame_err)), 0);
    end
  end

  task automatic snap();
    s_start = n_start; s_done = n_done; s_err = n_err;
    got_q.delete();
  endtask

  // One decoded bit after 'gap' idle cycles; last_p = {start, byte_vld, done, err} one edge later.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bit_vld = 1'b1; bit_dat = b;
    @(posedge clk); #1;
    last_p = {frame_start, rx_byte_vld, frame_done, frame_err};
    bit_vld = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], $urandom_range(0, maxgap));
  endtask

  task automatic send_preamble(input int maxgap);
    logic b;
    b = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      send_bit(b, $urandom_range(0, maxgap));
      b = ~b;
    end
  endtask

  task automatic relink();
    @(negedge clk); en = 1'b0;
    repeat (2) @(negedge clk); en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference outcome of a frame from its contents.
  function automatic void model(input logic [7:0] len, input logic [7:0] chk, output int nb,
                                output bit done, output bit err, output logic [1:0] code);
    logic [7:0] x;
    x = len; done = 0; err = 0; code = 2'b00; nb = 0;
    if (len == 8'd0 || len > 8'd64) begin
      err = 1; code = 2'b10;
    end else begin
      for (int i = 0; i < int'(len); i++) x = x ^ pay[i];
      nb = int'(len);
      if (x == chk) done = 1;
      else begin err = 1; code = 2'b01; end
    end
  endfunction

  task automatic check_frame(input string tag, input int nb, input bit done, input bit err,
                             input logic [1:0] code, input logic [7:0] len);
    repeat (2) @(posedge clk); #1;
    check({tag, "_start"}, n_start - s_start, 1);
    check({tag, "_done"}, n_done - s_done, done);
    check({tag, "_err"}, n_err - s_err, err);
    check({tag, "_nbytes"}, got_q.size(), nb);
    for (int i = 0; i < nb && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], pay[i]);
    if (err) check({tag, "_code"}, err_code, code);
    if (nb > 0) check({tag, "_rx_len"}, rx_len, len);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] len, input logic [7:0] chk,
                            input int maxgap);
    int nb; bit done; bit err; logic [1:0] code;
    model(len, chk, nb, done, err, code);
    snap();
    send_preamble(maxgap);
    send_byte(8'hD5, maxgap);
    check({tag, "_start_lat"}, last_p[3], 1);
    send_byte(len, maxgap);
    if (nb == 0) begin
      check({tag, "_lenerr_lat"}, last_p[0], 1);
    end else begin
      for (int i = 0; i < nb; i++) begin
        send_byte(pay[i], maxgap);
        check($sformatf("%s_vld_lat%0d", tag, i), last_p[2], 1);
      end
      send_byte(chk, maxgap);
      check({tag, "_done_lat"}, last_p[1], done);
      check({tag, "_err_lat"}, last_p[0], err);
    end
    check_frame(tag, nb, done, err, code, len);
  endtask

  initial begin
    int cyc;
    logic [7:0] len, x;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dec_en", dec_en, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_byte_vld", rx_byte_vld, 0);
    check("rst_rx_len", rx_len, 0);
    check("rst_start", frame_start, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    check("en_dec_en", dec_en, 1);

    // 1: basic valid frame
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame("t1", 8'd3, 8'h03, 0);

    // 2: bad checksum, then a good frame
    send_frame("t2_bad", 8'd3, 8'h04, 1);
    send_frame("t2_good", 8'd3, 8'h03, 2);

    // 3: length out of range
    send_frame("t3_len0", 8'h00, 8'h00, 1);
    send_frame("t3_len65", 8'h41, 8'h00, 1);

    // 4: watchdog in DATA
    snap();
    send_preamble(1);
    send_byte(8'hD5, 1);
    send_byte(8'd3, 1);
    send_byte(pay[0], 1);
    send_byte(pay[1], 1);
    cyc = 0;
    for (int c = 1; c <= 700; c++) begin
      @(posedge clk); #1;
      if (frame_err) begin cyc = c; break; end
    end
    check("t4_to_cycles", cyc, 648);
    check("t4_code", err_code, 2'b11);
    check("t4_busy", busy, 0);
    check("t4_dec_en", dec_en, 1);
    repeat (2) @(posedge clk); #1;
    check("t4_nbytes", got_q.size(), 2);
    check("t4_done", n_done - s_done, 0);
    check("t4_err", n_err - s_err, 1);

    // 5: en dropped mid-DATA
    snap();
    send_preamble(1);
    send_byte(8'hD5, 1);
    send_byte(8'd4, 1);
    send_byte(8'h5A, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("t5_dec_en", dec_en, 0);
    check("t5_busy", busy, 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_err", n_err - s_err, 0);
    check("t5_done", n_done - s_done, 0);
    check("t5_nbytes", got_q.size(), 1);
    pay[0] = 8'hA7; pay[1] = 8'h3C;
    send_frame("t5_after", 8'd2, 8'h02 ^ 8'hA7 ^ 8'h3C, 1);

    // 6a: short preamble then sync word
    relink();
    snap();
    for (int i = 0; i < 7; i++) send_bit(1'(~i[0]), 1);
    send_byte(8'hD5, 1);
    repeat (3) @(posedge clk); #1;
    check("t6a_start", n_start - s_start, 0);
    check("t6a_busy", busy, 0);

    // 6b: sync window exhausted, then a bare sync word must not match
    relink();
    snap();
    send_preamble(1);
    for (int i = 0; i < 32; i++) send_bit(1'b0, 1);
    send_byte(8'hD5, 1);
    repeat (3) @(posedge clk); #1;
    check("t6b_start", n_start - s_start, 0);
    check("t6b_err", n_err - s_err, 0);
    relink();
    pay[0] = 8'h00;
    send_frame("t6_after", 8'd1, 8'h01, 1);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) len = (r % 2 == 1) ? 8'h00 : 8'($urandom_range(65, 255));
      else len = 8'($urandom_range(1, 6));
      x = len;
      for (int i = 0; i < 6; i++) pay[i] = 8'($urandom_range(0, 255));
      if (len >= 8'd1 && len <= 8'd6)
        for (int i = 0; i < int'(len); i++) x = x ^ pay[i];
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      send_frame($sformatf("rnd%0d", f), len, x, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
